epm7032s_bitstream_loader: RTL
==============================

# epm7032s_bitstream_loader

- Byte-serial configuration loader that produces the 15033-bit `bitstream` configuration vector consumed by the `epm7032s` device model.
- Accepts a framed byte stream (data bytes plus an XOR checksum trailer) over a valid/ready handshake and assembles it MSB-first.
- Checks padding and checksum, then presents the completed bitstream atomically with a `loaded` flag.
- Sits between a testbench or programming front end and the device model's `bitstream` input.

## Interface

Parameters:
- `BITSTREAM_WIDTH`, 15033: configuration bits delivered to the device model.
- `DATA_BYTES`, 1880: ceil(BITSTREAM_WIDTH/8), the number of data bytes per frame.

Ports:
- `clock` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-high; takes effect on the rising edge of `clock`.
- `start` input 1: single-cycle pulse; begins or restarts a frame.
- `data_in` input 8: stream byte.
- `data_valid` input 1: `data_in` is valid.
- `data_ready` output 1: loader accepts a byte this cycle.
- `bitstream` output BITSTREAM_WIDTH: last successfully loaded configuration.
- `loaded` output 1: `bitstream` holds a verified frame.
- `busy` output 1: frame in progress.
- `error_code` output 2: 0 none, 1 padding error, 2 checksum error.
- `bytes_received` output 11: number of bytes accepted in the current frame (0..1881).

## Operation

- States: IDLE, LOAD, DONE, ERROR.
- Reset outputs and state:
  - state = IDLE.
  - `bitstream` = all zeros; `loaded` = 0; `busy` = 0; `error_code` = 0; `bytes_received` = 0.
  - Internal shift register and checksum accumulator = 0.
- `start` from any state enters LOAD and clears `bytes_received`, the shift register, the checksum accumulator, `loaded` and `error_code`.
  - `bitstream` keeps its previous value until a new frame completes.
- `data_ready` = (state == LOAD) && !`start`, combinational. A byte is accepted when `data_valid` && `data_ready` are both high.
- Frame layout is DATA_BYTES data bytes followed by 1 checksum byte, 1881 bytes total.
- Bit order:
  - The first byte's bit 7 maps to `bitstream[BITSTREAM_WIDTH-1]`. Bits are consumed MSB-first within each byte and continue toward index 0.
  - Bytes 0..1878 contribute 8 bits each, covering indices 15032..1.
  - Byte 1879 contributes its bit 7 only, to index 0. Its bits 6:0 are padding and must be 0.
- Checksum: the XOR of all DATA_BYTES data bytes, including the padding byte as received. Byte 1880 must equal this value.
- Completion on acceptance of byte 1880:
  - Padding nonzero → ERROR, `error_code` = 1. Padding takes priority over checksum.
  - Otherwise checksum mismatch → ERROR, `error_code` = 2.
  - Otherwise → DONE: `bitstream` is updated from the shift register and `loaded` = 1.
- In ERROR, `bitstream` is untouched and `loaded` stays 0. Leave ERROR only via `start` or `reset`.
- `busy` = (state == LOAD).
- In IDLE, DONE and ERROR, `data_valid` is ignored.

## Timing

- Accepted byte: `bytes_received` increments and is visible the cycle after the accepting edge.
- Frame completion: `bitstream`, `loaded` and `error_code` update on the same edge that accepts byte 1880 and are visible the next cycle. No additional latency.
- Full-rate load with `data_valid` held high takes 1881 cycles from the first `data_ready`.
- Gaps in `data_valid` stall the frame indefinitely. There is no timeout.
- `start` and `data_valid` in the same cycle: `start` wins and the byte is not accepted.
- `start` mid-frame (abort): the partial frame is discarded and the new frame begins with byte 0 on the following cycle.
- `reset` mid-frame: all outputs return to reset values on that edge, including clearing a previously loaded `bitstream`.
- `bitstream` never exposes a partially assembled frame.

## Structure

- Shared package `epm7032s_pkg` holds:
  - Constants BITSTREAM_WIDTH = 15033, DATA_BYTES = 1880, FRAME_BYTES = 1881 and PAD_MASK = 8'h7F.
  - State enum `loader_state_t`.
  - Error-code constants.
- Sub-module `bitstream_shift_register`: BITSTREAM_WIDTH-bit register with clear, shift-by-8 and shift-by-1 modes. The top level holds the FSM, counter, checksum and output register.

## Test plan

- Nominal frame:
  - Stimulus: `start`, then 1879 bytes of 0xA5, then 0x80, then checksum 0x25.
  - Response: `loaded` = 1, `error_code` = 0; `bitstream[15032]` = 1, `bitstream[15031]` = 0, `bitstream[0]` = 1; `bytes_received` = 1881.
- Checksum error:
  - Stimulus: same frame with checksum 0x24.
  - Response: `error_code` = 2, `loaded` = 0, `bitstream` unchanged (zeros after reset).
- Padding error:
  - Stimulus: byte 1879 = 0x81, checksum 0x24 (correct for that data).
  - Response: `error_code` = 1.
- Backpressure and gaps:
  - Stimulus: nominal frame with `data_valid` randomly deasserted about 50% of cycles.
  - Response: identical result to the nominal frame.
- Abort:
  - Stimulus: `start`, 500 bytes of 0xFF, `start` asserted together with `data_valid`, then the nominal frame.
  - Response: the colliding byte is not accepted; result equals the nominal frame; `bytes_received` = 1881.
- Reset mid-load:
  - Stimulus: after a successful nominal load, `start`, 100 bytes, then `reset`.
  - Response: `bitstream` = 0, `loaded` = 0, `busy` = 0, `data_ready` = 0 the next cycle.

Source files
------------

// File: rtl/epm7032s_pkg.sv
// Shared constants and types for the EPM7032S configuration bitstream loader.
package epm7032s_pkg;

    localparam int BITSTREAM_WIDTH = 15033;
    localparam int DATA_BYTES      = 1880;
    localparam int FRAME_BYTES     = 1881;
    localparam logic [7:0] PAD_MASK = 8'h7F;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE,
        ERROR
    } loader_state_t;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_PADDING  = 2'd1;
    localparam logic [1:0] ERR_CHECKSUM = 2'd2;

    typedef enum logic [1:0] {
        SR_HOLD,
        SR_CLEAR,
        SR_SHIFT8,
        SR_SHIFT1
    } shift_mode_t;

endpackage

// File: rtl/bitstream_shift_register.sv
// Assembly register for the configuration vector; bytes enter at the LSB end so
// the first bit received ends up at the MSB once the register is full.
module bitstream_shift_register
    import epm7032s_pkg::*;
#(
    parameter int WIDTH = BITSTREAM_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  shift_mode_t      mode,
    input  logic [7:0]       data,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clock) begin
        if (reset) begin
            q <= '0;
        end else begin
            case (mode)
                SR_CLEAR:  q <= '0;
                SR_SHIFT8: q <= {q[WIDTH-9:0], data};
                // Final data byte carries a single real bit; the rest is padding.
                SR_SHIFT1: q <= {q[WIDTH-2:0], data[7]};
                default:   q <= q;
            endcase
        end
    end

endmodule

// File: rtl/epm7032s_bitstream_loader.sv
// Byte-serial loader: assembles a framed, checksummed byte stream into the
// EPM7032S configuration vector and publishes it only once the frame verifies.
module epm7032s_bitstream_loader
    import epm7032s_pkg::*;
#(
    parameter int BITSTREAM_WIDTH = epm7032s_pkg::BITSTREAM_WIDTH,
    parameter int DATA_BYTES      = epm7032s_pkg::DATA_BYTES
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic [7:0]                 data_in,
    input  logic                       data_valid,
    output logic                       data_ready,
    output logic [BITSTREAM_WIDTH-1:0] bitstream,
    output logic                       loaded,
    output logic                       busy,
    output logic [1:0]                 error_code,
    output logic [10:0]                bytes_received
);

    loader_state_t state, next_state;
    shift_mode_t   sr_mode;

    logic [BITSTREAM_WIDTH-1:0] sr_q;
    logic [10:0]                byte_count;
    logic [7:0]                 checksum;
    logic                       pad_bad;
    logic                       accept;
    logic                       is_pad_byte;
    logic                       is_check_byte;

    assign data_ready     = (state == LOAD) && !start;
    assign busy           = (state == LOAD);
    assign accept         = data_valid && data_ready;
    assign bytes_received = byte_count;
    assign is_pad_byte    = (byte_count == 11'(DATA_BYTES - 1));
    assign is_check_byte  = (byte_count == 11'(DATA_BYTES));

    bitstream_shift_register #(
        .WIDTH (BITSTREAM_WIDTH)
    ) u_shift (
        .clock (clock),
        .reset (reset),
        .mode  (sr_mode),
        .data  (data_in),
        .q     (sr_q)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        sr_mode    = SR_HOLD;
        if (start) begin
            next_state = LOAD;
            sr_mode    = SR_CLEAR;
        end else if (accept) begin
            if (is_check_byte) begin
                next_state = (!pad_bad && (data_in == checksum)) ? DONE : ERROR;
            end else if (is_pad_byte) begin
                sr_mode = SR_SHIFT1;
            end else begin
                sr_mode = SR_SHIFT8;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            byte_count <= '0;
            checksum   <= '0;
            pad_bad    <= 1'b0;
            bitstream  <= '0;
            loaded     <= 1'b0;
            error_code <= ERR_NONE;
        end else if (start) begin
            byte_count <= '0;
            checksum   <= '0;
            pad_bad    <= 1'b0;
            loaded     <= 1'b0;
            error_code <= ERR_NONE;
        end else if (accept) begin
            byte_count <= byte_count + 11'd1;
            if (!is_check_byte) begin
                checksum <= checksum ^ data_in;
            end
            // Padding is remembered here because its bits never enter the shift register.
            if (is_pad_byte) begin
                pad_bad <= |(data_in & PAD_MASK);
            end
            if (is_check_byte) begin
                if (pad_bad) begin
                    error_code <= ERR_PADDING;
                end else if (data_in != checksum) begin
                    error_code <= ERR_CHECKSUM;
                end else begin
                    bitstream <= sr_q;
                    loaded    <= 1'b1;
                end
            end
        end
    end

endmodule
